// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one external combinational ALU
// between two requesters using valid/ready request and response channels.
module alu_arbiter #(
    parameter int DW  = 128,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_r,
    input  logic [DW-1:0]  req0_s,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_r,
    input  logic [DW-1:0]  req1_s,
    input  logic [OPW-1:0] req1_op,

    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic [DW-1:0]  resp0_y,
    output logic           resp0_n,
    output logic           resp0_z,
    output logic           resp0_c,

    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [DW-1:0]  resp1_y,
    output logic           resp1_n,
    output logic           resp1_z,
    output logic           resp1_c,

    output logic [DW-1:0]  alu_r,
    output logic [DW-1:0]  alu_s,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_y,
    input  logic           alu_n,
    input  logic           alu_z,
    input  logic           alu_c,

    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_grant_id;
    logic [DW-1:0]  r_opr;
    logic [DW-1:0]  r_ops;
    logic [OPW-1:0] r_opop;
    logic [DW-1:0]  r_y;
    logic           r_n;
    logic           r_z;
    logic           r_c;

    logic           w_any_req;
    logic           w_grant_id;
    logic           w_accept;
    logic           w_resp_ready;

    // NOTE: every signal assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        w_any_req    = req0_valid | req1_valid;
        // On contention the requester that did not win last time goes next.
        w_grant_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept     = (r_state == IDLE) && w_any_req;
        w_resp_ready = r_grant_id ? resp1_ready : resp0_ready;
    end

    assign req0_ready  = w_accept && !w_grant_id;
    assign req1_ready  = w_accept &&  w_grant_id;

    assign resp0_valid = (r_state == RESP) && !r_grant_id;
    assign resp1_valid = (r_state == RESP) &&  r_grant_id;

    assign resp0_y = r_y;
    assign resp0_n = r_n;
    assign resp0_z = r_z;
    assign resp0_c = r_c;
    assign resp1_y = r_y;
    assign resp1_n = r_n;
    assign resp1_z = r_z;
    assign resp1_c = r_c;

    assign alu_r  = r_opr;
    assign alu_s  = r_ops;
    assign alu_op = r_opop;

    assign busy = (r_state != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and result registers are reset too, because the ALU inputs must read zero after reset.
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_opr        <= '0;
            r_ops        <= '0;
            r_opop       <= '0;
            r_y          <= '0;
            r_n          <= 1'b0;
            r_z          <= 1'b0;
            r_c          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opr        <= w_grant_id ? req1_r  : req0_r;
                        r_ops        <= w_grant_id ? req1_s  : req0_s;
                        r_opop       <= w_grant_id ? req1_op : req0_op;
                        r_grant_id   <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_y     <= alu_y;
                    r_n     <= alu_n;
                    r_z     <= alu_z;
                    r_c     <= alu_c;
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model for ops 0000 (pass S), 0100 (add), 1100 (negate S).
module tb_alu_arbiter;

    localparam int DW  = 128;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [DW-1:0]  req0_r, req0_s, req1_r, req1_s;
    logic [OPW-1:0] req0_op, req1_op;
    logic           resp0_valid, resp1_valid;
    logic           resp0_ready, resp1_ready;
    logic [DW-1:0]  resp0_y, resp1_y;
    logic           resp0_n, resp0_z, resp0_c;
    logic           resp1_n, resp1_z, resp1_c;
    logic [DW-1:0]  alu_r, alu_s, alu_y;
    logic [OPW-1:0] alu_op;
    logic           alu_n, alu_z, alu_c;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    always #5 clk = ~clk;

    // Reference ALU driven from the arbiter's ALU ports.
    logic [DW:0] alu_wide;
    always_comb begin
        case (alu_op)
            4'b0100: alu_wide = {1'b0, alu_r} + {1'b0, alu_s};
            4'b1100: alu_wide = {(DW+1){1'b0}} - {1'b0, alu_s};
            default: alu_wide = {1'b0, alu_s};
        endcase
        alu_y = alu_wide[DW-1:0];
        alu_c = alu_wide[DW];
        alu_n = alu_wide[DW-1];
        alu_z = (alu_wide[DW-1:0] == '0);
    end

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r(req0_r), .req0_s(req0_s), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r(req1_r), .req1_s(req1_s), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y),
        .resp0_n(resp0_n), .resp0_z(resp0_z), .resp0_c(resp0_c),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y),
        .resp1_n(resp1_n), .resp1_z(resp1_z), .resp1_c(resp1_c),
        .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op),
        .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point away from the active edge.
    task automatic sample();
        @(negedge clk);
    endtask

    // One uncontended operation on port p, checking grant, latency and result.
    task automatic single_op(input bit p, input logic [DW-1:0] r, input logic [DW-1:0] s,
                             input logic [OPW-1:0] op, input logic [DW-1:0] ey,
                             input logic en, input logic ez, input logic ec);
        if (p) begin
            req1_valid = 1'b1; req1_r = r; req1_s = s; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_r = r; req0_s = s; req0_op = op;
        end
        sample();
        check("req_ready_granted", {127'd0, p ? req1_ready : req0_ready}, 1);
        check("req_ready_other",   {127'd0, p ? req0_ready : req1_ready}, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (p) req1_s = ~s; else req0_s = ~s;
        sample();
        check("exec_busy",   {127'd0, busy}, 1);
        check("exec_alu_s",  alu_s, s);
        check("exec_alu_op", {124'd0, alu_op}, {124'd0, op});
        check("exec_no_resp", {126'd0, resp1_valid, resp0_valid}, 0);
        step();
        sample();
        check("resp_valid", {126'd0, resp1_valid, resp0_valid}, p ? 2 : 1);
        check("resp_y", p ? resp1_y : resp0_y, ey);
        check("resp_nzc", {125'd0, p ? {resp1_n, resp1_z, resp1_c} : {resp0_n, resp0_z, resp0_c}},
              {125'd0, en, ez, ec});
        step();
        sample();
        check("back_to_idle", {127'd0, busy}, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_r = '0; req0_s = '0; req0_op = '0;
        req1_r = '0; req1_s = '0; req1_op = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        // Reset state
        step(); step();
        rst = 1'b0;
        sample();
        check("rst_busy", {127'd0, busy}, 0);
        check("rst_ready", {126'd0, req1_ready, req0_ready}, 0);
        check("rst_resp_valid", {126'd0, resp1_valid, resp0_valid}, 0);
        check("rst_alu_r", alu_r, 0);
        check("rst_alu_s", alu_s, 0);
        check("rst_alu_op", {124'd0, alu_op}, 0);
        check("rst_resp_y", resp0_y, 0);
        step();

        // Single add; S is changed after the handshake inside single_op
        single_op(1'b0, 128'd5, 128'd7, 4'b0100, 128'd12, 1'b0, 1'b0, 1'b0);
        step();
        // Overflow flags on port 1
        single_op(1'b1, ONES, 128'd1, 4'b0100, 128'd0, 1'b0, 1'b1, 1'b1);
        step();
        single_op(1'b1, 128'd0, 128'd1, 4'b1100, ONES, 1'b1, 1'b0, 1'b1);
        step();
        // Undefined op code passes S
        single_op(1'b0, 128'd3, 128'h55, 4'b1111, 128'h55, 1'b0, 1'b0, 1'b0);

        // Contention from reset: 0 first, then strict alternation
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_r = 128'd1; req0_s = 128'd2; req0_op = 4'b0100;
        req1_valid = 1'b1; req1_r = 128'd4; req1_s = 128'd9; req1_op = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("cont_grant", {126'd0, req1_ready, req0_ready}, (i % 2) ? 2 : 1);
            step();
            step();
            sample();
            check("cont_resp_port", {126'd0, resp1_valid, resp0_valid}, (i % 2) ? 2 : 1);
            check("cont_resp_y", (i % 2) ? resp1_y : resp0_y, (i % 2) ? 128'd9 : 128'd3);
            step();
        end

        // Backpressure on port 0 while port 1 keeps requesting
        resp0_ready = 1'b0;
        sample();
        check("bp_grant0", {126'd0, req1_ready, req0_ready}, 1);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            sample();
            check("bp_hold_valid", {126'd0, resp1_valid, resp0_valid}, 1);
            check("bp_hold_y", resp0_y, 128'd3);
            check("bp_req1_blocked", {127'd0, req1_ready}, 0);
            step();
        end
        resp0_ready = 1'b1;
        step();
        sample();
        check("bp_grant1_after", {126'd0, req1_ready, req0_ready}, 2);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        sample();
        check("bp_resp1_y", resp1_y, 128'd9);
        check("bp_resp1_valid", {126'd0, resp1_valid, resp0_valid}, 2);
        step();

        // Reset during EXEC of a port-0 operation
        req0_valid = 1'b1; req0_s = 128'h77; req0_op = 4'b0000;
        sample();
        check("mid_grant0", {127'd0, req0_ready}, 1);
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check("mid_busy", {127'd0, busy}, 0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                sample();
                seen = seen | resp0_valid | resp1_valid;
                step();
            end
            check("mid_no_resp", {127'd0, seen}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        sample();
        check("mid_next_grant", {126'd0, req1_ready, req0_ready}, 1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
